// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues one imem request at a time, hands words to the decoder.
// Define FETCH_COUNT_EN to add the 16-bit fetch_count output (accepted instructions).
module instruction_fetch #(
  parameter int          BITS      = 16,
  parameter int          ADDR_BITS = 8,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [BITS-1:0]      imem_rdata,
  output logic [BITS-1:0]      instr,
  output logic [ADDR_BITS-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]          fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_t;

  localparam logic [ADDR_BITS-1:0] RESET_PC_W = ADDR_BITS'(RESET_PC);

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_BITS-1:0] r_pc;
  logic [ADDR_BITS-1:0] w_pc_next;
  logic                 r_req;
  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS-1:0] w_addr_next;
  logic [BITS-1:0]      r_instr;
  logic [BITS-1:0]      w_instr_next;
  logic [ADDR_BITS-1:0] r_instr_pc;
  logic [ADDR_BITS-1:0] w_instr_pc_next;
  logic                 r_valid;
  logic                 w_valid_next;
  logic                 w_req_next;
  logic                 w_enter_req;
  logic [ADDR_BITS-1:0] w_pc_target;

  assign w_pc_target = redirect ? redirect_pc : r_pc;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_valid_next    = r_valid;
    case (r_state)
      IDLE: begin
        if (redirect) w_pc_next = redirect_pc;
        if (!stall) w_state_next = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            w_pc_next    = redirect_pc;
            w_state_next = stall ? IDLE : REQ;
          end else begin
            w_instr_next    = imem_rdata;
            w_instr_pc_next = r_addr;
            w_valid_next    = 1'b1;
            w_pc_next       = r_pc + ADDR_BITS'(1);
            w_state_next    = FULL;
          end
        end else if (redirect) begin
          w_pc_next    = redirect_pc;
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The outstanding request belongs to the old path; its data is dropped.
        if (redirect) w_pc_next = redirect_pc;
        if (imem_ack) w_state_next = stall ? IDLE : REQ;
      end
      FULL: begin
        if (redirect) begin
          w_valid_next = 1'b0;
          w_pc_next    = redirect_pc;
          w_state_next = IDLE;
        end else if (instr_ready) begin
          w_valid_next = 1'b0;
          w_state_next = stall ? IDLE : REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // REQ -> REQ only happens after an ack, so it is a fresh request too.
  assign w_enter_req = (w_state_next == REQ) && ((r_state != REQ) || imem_ack);
  assign w_addr_next = w_enter_req ? w_pc_target : r_addr;
  assign w_req_next  = (w_state_next == REQ) || (w_state_next == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC_W;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_valid    <= w_valid_next;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

`ifdef FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (r_valid && instr_ready && !redirect) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
